// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared encodings for the multi-cycle RISC-V control FSM
package multicycle_ctrl_pkg;

  // Immediate generator selects, unchanged from the existing datapath codes
  localparam logic [1:0] I_TYPE = 2'b00;
  localparam logic [1:0] S_TYPE = 2'b01;
  localparam logic [1:0] B_TYPE = 2'b10;
  localparam logic [1:0] J_TYPE = 2'b11;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] ST_FETCH   = 3'd0;
  localparam logic [2:0] ST_DECODE  = 3'd1;
  localparam logic [2:0] ST_EXECUTE = 3'd2;
  localparam logic [2:0] ST_MEM     = 3'd3;
  localparam logic [2:0] ST_WB      = 3'd4;
  localparam logic [2:0] ST_HALT    = 3'd5;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  typedef enum logic [3:0] {
    CLS_OP,
    CLS_OP_IMM,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI,
    CLS_AUIPC
  } instr_class_t;

endpackage

// File: rtl/multicycle_ctrl_opcode_class.sv
// rtl/multicycle_ctrl_opcode_class.sv - combinational opcode to {imm_sel, class, legal} decode
module opcode_class
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0]   opcode,
  output logic [1:0]   imm_sel,
  output instr_class_t cls,
  output logic         legal
);

  always_comb begin
    imm_sel = I_TYPE;
    cls     = CLS_OP;
    legal   = 1'b1;
    case (opcode)
      OPC_OP:     cls = CLS_OP;
      OPC_OP_IMM: cls = CLS_OP_IMM;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_JALR:   cls = CLS_JALR;
      OPC_STORE: begin
        cls     = CLS_STORE;
        imm_sel = S_TYPE;
      end
      OPC_BRANCH: begin
        cls     = CLS_BRANCH;
        imm_sel = B_TYPE;
      end
      OPC_JAL: begin
        cls     = CLS_JAL;
        imm_sel = J_TYPE;
      end
      OPC_LUI: begin
        cls     = CLS_LUI;
        imm_sel = J_TYPE;
      end
      OPC_AUIPC: begin
        cls     = CLS_AUIPC;
        imm_sel = J_TYPE;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - fetch/decode/execute/mem/writeback sequencer for the multi-cycle datapath
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      Instruction,
  input  logic             Branch_Cond,
  input  logic             Mem_Ready,
  output logic             Mem_Req,
  output logic             Mem_Write,
  output logic             Mem_Addr_Sel,
  output logic             IR_Write,
  output logic             PC_Write,
  output logic             PC_Sel,
  output logic [1:0]       Imm_Sel,
  output logic             ALU_Src_A,
  output logic             ALU_Src_B,
  output logic [1:0]       ALU_Op,
  output logic             Reg_Write,
  output logic [1:0]       WB_Sel,
  output logic             Illegal_Instr,
  output logic             Bus_Error,
  output logic [CNT_W-1:0] Retired_Count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  instr_class_t      cls_q;
  logic [1:0]        dec_imm;
  instr_class_t      dec_cls;
  logic              dec_legal;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout;
  logic              unused_instr_bits;

  assign unused_instr_bits = ^Instruction[31:7];

  opcode_class u_opcode_class (
    .opcode  (Instruction[6:0]),
    .imm_sel (dec_imm),
    .cls     (dec_cls),
    .legal   (dec_legal)
  );

  // Fires on the wait cycle that would take the counter to MEM_TIMEOUT; a ready in that cycle wins
  assign timeout = Mem_Req && !Mem_Ready && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH: begin
        if (Mem_Ready)    state_nxt = ST_DECODE;
        else if (timeout) state_nxt = ST_HALT;
      end
      ST_DECODE:  state_nxt = dec_legal ? ST_EXECUTE : ST_HALT;
      ST_EXECUTE: begin
        case (cls_q)
          CLS_BRANCH:          state_nxt = ST_FETCH;
          CLS_LOAD, CLS_STORE: state_nxt = ST_MEM;
          default:             state_nxt = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (Mem_Ready)    state_nxt = (cls_q == CLS_STORE) ? ST_FETCH : ST_WB;
        else if (timeout) state_nxt = ST_HALT;
      end
      ST_WB:   state_nxt = ST_FETCH;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_FETCH;
    endcase
  end

  // Outputs are forced low while Reset is high so an in-flight request drops immediately
  always_comb begin
    Mem_Req      = 1'b0;
    Mem_Write    = 1'b0;
    Mem_Addr_Sel = 1'b0;
    IR_Write     = 1'b0;
    PC_Write     = 1'b0;
    PC_Sel       = 1'b0;
    ALU_Src_A    = 1'b0;
    ALU_Src_B    = 1'b0;
    ALU_Op       = ALU_ADD;
    Reg_Write    = 1'b0;
    WB_Sel       = WB_ALU;
    if (!Reset) begin
      case (state)
        ST_FETCH: begin
          Mem_Req  = 1'b1;
          IR_Write = Mem_Ready;
        end
        ST_EXECUTE: begin
          case (cls_q)
            CLS_OP: ALU_Op = ALU_FUNCT;
            CLS_OP_IMM: begin
              ALU_Op    = ALU_FUNCT;
              ALU_Src_B = 1'b1;
            end
            CLS_LOAD, CLS_STORE, CLS_JALR: ALU_Src_B = 1'b1;
            CLS_BRANCH: begin
              ALU_Op    = ALU_BRANCH;
              ALU_Src_A = 1'b1;
              ALU_Src_B = 1'b1;
              PC_Write  = 1'b1;
              PC_Sel    = Branch_Cond;
            end
            CLS_JAL, CLS_AUIPC: begin
              ALU_Src_A = 1'b1;
              ALU_Src_B = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          Mem_Req      = 1'b1;
          Mem_Addr_Sel = 1'b1;
          Mem_Write    = (cls_q == CLS_STORE);
          PC_Write     = (cls_q == CLS_STORE) && Mem_Ready;
        end
        ST_WB: begin
          Reg_Write = 1'b1;
          PC_Write  = 1'b1;
          case (cls_q)
            CLS_LOAD: WB_Sel = WB_MEM;
            CLS_JAL, CLS_JALR: begin
              WB_Sel = WB_PC4;
              PC_Sel = 1'b1;
            end
            CLS_LUI: WB_Sel = WB_IMM;
            default: WB_Sel = WB_ALU;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= ST_FETCH;
      cls_q         <= CLS_OP;
      Imm_Sel       <= I_TYPE;
      Illegal_Instr <= 1'b0;
      Bus_Error     <= 1'b0;
      Retired_Count <= '0;
      wait_cnt      <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_DECODE) begin
        cls_q   <= dec_cls;
        Imm_Sel <= dec_imm;
        if (!dec_legal) Illegal_Instr <= 1'b1;
      end
      if (timeout) Bus_Error <= 1'b1;
      if (PC_Write) Retired_Count <= Retired_Count + CNT_W'(1);
      if (Mem_Req && !Mem_Ready && !timeout) wait_cnt <= wait_cnt + WAIT_W'(1);
      else wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed and randomized instruction sequences against a behavioural model
module tb_multicycle_ctrl;

  localparam int TMO = 4;
  localparam int CW  = 4;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [31:0]   Instruction;
  logic          Branch_Cond;
  logic          Mem_Ready;
  logic          Mem_Req, Mem_Write, Mem_Addr_Sel, IR_Write, PC_Write, PC_Sel;
  logic [1:0]    Imm_Sel, ALU_Op, WB_Sel;
  logic          ALU_Src_A, ALU_Src_B, Reg_Write, Illegal_Instr, Bus_Error;
  logic [CW-1:0] Retired_Count;

  int vectors     = 0;
  int miscompares = 0;
  int rc          = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .Branch_Cond(Branch_Cond),
    .Mem_Ready(Mem_Ready), .Mem_Req(Mem_Req), .Mem_Write(Mem_Write), .Mem_Addr_Sel(Mem_Addr_Sel),
    .IR_Write(IR_Write), .PC_Write(PC_Write), .PC_Sel(PC_Sel), .Imm_Sel(Imm_Sel),
    .ALU_Src_A(ALU_Src_A), .ALU_Src_B(ALU_Src_B), .ALU_Op(ALU_Op), .Reg_Write(Reg_Write),
    .WB_Sel(WB_Sel), .Illegal_Instr(Illegal_Instr), .Bus_Error(Bus_Error),
    .Retired_Count(Retired_Count)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       legal;
    logic [1:0] imm;
    logic [1:0] alu_op;
    logic       src_a;
    logic       src_b;
    logic       is_mem;
    logic       is_store;
    logic       is_branch;
    logic       has_wb;
    logic       is_jump;
    logic [1:0] wb_sel;
  } exp_t;

  // What each RV32I base opcode asks of the control unit
  function automatic exp_t model(input logic [6:0] opc);
    exp_t e;
    e = '0;
    e.legal = 1'b1;
    e.imm = 2'b00;
    case (opc)
      7'h33: begin e.alu_op = 2'b10; e.has_wb = 1; end
      7'h13: begin e.alu_op = 2'b10; e.src_b = 1; e.has_wb = 1; end
      7'h03: begin e.src_b = 1; e.is_mem = 1; e.has_wb = 1; e.wb_sel = 2'b01; end
      7'h23: begin e.imm = 2'b01; e.src_b = 1; e.is_mem = 1; e.is_store = 1; end
      7'h63: begin e.imm = 2'b10; e.alu_op = 2'b01; e.src_a = 1; e.src_b = 1; e.is_branch = 1; end
      7'h6F: begin e.imm = 2'b11; e.src_a = 1; e.src_b = 1; e.has_wb = 1; e.is_jump = 1; e.wb_sel = 2'b10; end
      7'h67: begin e.src_b = 1; e.has_wb = 1; e.is_jump = 1; e.wb_sel = 2'b10; end
      7'h37: begin e.imm = 2'b11; e.has_wb = 1; e.wb_sel = 2'b11; end
      7'h17: begin e.imm = 2'b11; e.src_a = 1; e.src_b = 1; e.has_wb = 1; end
      default: e.legal = 1'b0;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic retire();
    rc = (rc + 1) % (1 << CW);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Mem_Ready = 1'b0;
    #2;
    chk("rst_mem_req", Mem_Req, 0);
    chk("rst_enables", {IR_Write, PC_Write, Reg_Write, Mem_Write}, 0);
    chk("rst_illegal", Illegal_Instr, 0);
    chk("rst_bus_error", Bus_Error, 0);
    chk("rst_imm_sel", Imm_Sel, 2'b00);
    chk("rst_retired", Retired_Count, 0);
    rc = 0;
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  // Drives one instruction from fetch to completion; fd/md are non-ready cycles before Mem_Ready
  task automatic run_instr(input logic [31:0] ins, input logic bc, input int fd, input int md);
    exp_t e;
    e = model(ins[6:0]);
    Instruction = ins;
    Branch_Cond = bc;
    for (int k = 0; k <= fd; k++) begin
      Mem_Ready = (k == fd);
      @(negedge Clk);
      chk("fetch_req", Mem_Req, 1);
      chk("fetch_addr_sel", Mem_Addr_Sel, 0);
      chk("fetch_mem_write", Mem_Write, 0);
      chk("fetch_ir_write", IR_Write, (k == fd));
      chk("fetch_pc_write", PC_Write, 0);
      chk("fetch_retired", Retired_Count, rc);
      chk("fetch_bus_error", Bus_Error, 0);
      @(posedge Clk); #1;
    end
    Mem_Ready = 1'($urandom_range(0, 1));
    @(negedge Clk);
    chk("decode_req", Mem_Req, 0);
    chk("decode_enables", {IR_Write, PC_Write, Reg_Write}, 0);
    @(posedge Clk); #1;
    if (!e.legal) begin
      for (int k = 0; k < 4; k++) begin
        Mem_Ready = 1'($urandom_range(0, 1));
        @(negedge Clk);
        chk("halt_illegal", Illegal_Instr, 1);
        chk("halt_req", Mem_Req, 0);
        chk("halt_enables", {IR_Write, PC_Write, Reg_Write}, 0);
        chk("halt_retired", Retired_Count, rc);
        @(posedge Clk); #1;
      end
      return;
    end
    Mem_Ready = 1'($urandom_range(0, 1));
    @(negedge Clk);
    chk("exe_imm_sel", Imm_Sel, e.imm);
    chk("exe_alu_op", ALU_Op, e.alu_op);
    chk("exe_src_a", ALU_Src_A, e.src_a);
    chk("exe_src_b", ALU_Src_B, e.src_b);
    chk("exe_req", Mem_Req, 0);
    chk("exe_pc_write", PC_Write, e.is_branch);
    if (e.is_branch) chk("exe_pc_sel", PC_Sel, bc);
    chk("exe_reg_write", Reg_Write, 0);
    @(posedge Clk); #1;
    if (e.is_branch) retire();
    if (e.is_mem) begin
      for (int k = 0; k <= md; k++) begin
        Mem_Ready = (k == md);
        @(negedge Clk);
        chk("mem_req", Mem_Req, 1);
        chk("mem_addr_sel", Mem_Addr_Sel, 1);
        chk("mem_write", Mem_Write, e.is_store);
        chk("mem_imm_sel", Imm_Sel, e.imm);
        chk("mem_pc_write", PC_Write, (e.is_store && k == md));
        if (e.is_store && k == md) chk("mem_pc_sel", PC_Sel, 0);
        chk("mem_reg_write", Reg_Write, 0);
        @(posedge Clk); #1;
        if (e.is_store && k == md) retire();
      end
    end
    if (e.has_wb) begin
      Mem_Ready = 1'($urandom_range(0, 1));
      @(negedge Clk);
      chk("wb_reg_write", Reg_Write, 1);
      chk("wb_sel", WB_Sel, e.wb_sel);
      chk("wb_pc_write", PC_Write, 1);
      chk("wb_pc_sel", PC_Sel, e.is_jump);
      chk("wb_imm_sel", Imm_Sel, e.imm);
      chk("wb_req", Mem_Req, 0);
      @(posedge Clk); #1;
      retire();
    end
  endtask

  logic [6:0]  pool [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
  logic [31:0] r;

  initial begin
    Instruction = 32'h0;
    Branch_Cond = 1'b0;
    Mem_Ready   = 1'b0;
    #1;
    do_reset();

    run_instr(32'h00500093, 1'b0, 0, 0);
    run_instr(32'h0020A423, 1'b0, 0, 3);
    run_instr(32'h00208463, 1'b1, 0, 0);
    run_instr(32'h00208463, 1'b0, 0, 0);
    run_instr(32'h010000EF, 1'b0, 0, 0);
    run_instr(32'h123452B7, 1'b0, 0, 0);
    run_instr(32'h00500093, 1'b0, TMO - 1, 0);

    for (int i = 0; i < 40; i++) begin
      r = $urandom();
      run_instr({r[31:7], pool[$urandom_range(0, 8)]}, 1'($urandom_range(0, 1)),
                $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1));
    end
    Mem_Ready = 1'b0;
    @(negedge Clk);
    chk("random_retired", Retired_Count, rc);
    @(posedge Clk); #1;

    do_reset();
    run_instr(32'h0000007F, 1'b0, 0, 0);
    do_reset();
    run_instr(32'h00500093, 1'b0, 0, 0);

    do_reset();
    Instruction = 32'h00500093;
    for (int k = 0; k < TMO; k++) begin
      Mem_Ready = 1'b0;
      @(negedge Clk);
      chk("tmo_wait_req", Mem_Req, 1);
      chk("tmo_wait_bus_error", Bus_Error, 0);
      @(posedge Clk); #1;
    end
    for (int k = 0; k < 3; k++) begin
      Mem_Ready = 1'($urandom_range(0, 1));
      @(negedge Clk);
      chk("tmo_bus_error", Bus_Error, 1);
      chk("tmo_req_dropped", Mem_Req, 0);
      chk("tmo_ir_write", IR_Write, 0);
      @(posedge Clk); #1;
    end

    do_reset();
    Mem_Ready = 1'b0;
    @(negedge Clk);
    chk("midreq_req_before", Mem_Req, 1);
    #2;
    Reset = 1'b1;
    #1;
    chk("midreq_req_dropped", Mem_Req, 0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    rc = 0;
    run_instr(32'h00500093, 1'b0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
